// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer for the NCO.
// Latches a sweep configuration on an accepted start, then steps the frequency
// control word from f_start towards f_stop, holding each value for dwell+1
// clocks. Supports single, sawtooth-repeat and triangle-repeat sweeps and
// pulses the NCO phase reset once at sweep start. All outputs are registered.
module nco_sweep_ctrl #(
  parameter int N = 16,
  parameter int D = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   mode,
  input  logic [N-1:0] f_start,
  input  logic [N-1:0] f_stop,
  input  logic [N-1:0] f_step,
  input  logic [D-1:0] dwell,
  output logic [N-1:0] fcw,
  output logic         nco_rst,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic {S_IDLE, S_DWELL} state_t;

  state_t       r_state, w_state_next;
  logic [N-1:0] r_fcw, w_fcw_next;
  logic         r_nco_rst, w_nco_rst_next;
  logic         r_busy, w_busy_next;
  logic         r_done, w_done_next;
  logic         r_err, w_err_next;
  logic         r_dir, w_dir_next;       // 0 = up, 1 = down (triangle mode only)
  logic [D-1:0] r_cnt, w_cnt_next;

  // Shadow copy of the configuration, frozen for the whole sweep
  logic [1:0]   r_mode, w_mode_next;
  logic [N-1:0] r_f_start, w_f_start_next;
  logic [N-1:0] r_f_stop, w_f_stop_next;
  logic [N-1:0] r_f_step, w_f_step_next;
  logic [D-1:0] r_dwell, w_dwell_next;

  // One extra bit on the sum/difference so the clamp sees overflow/underflow
  logic [N:0]   w_sum, w_diff;
  logic [N-1:0] w_up_fcw, w_dn_fcw;

  assign w_sum    = {1'b0, r_fcw} + {1'b0, r_f_step};
  assign w_diff   = {1'b0, r_fcw} - {1'b0, r_f_step};
  assign w_up_fcw = (w_sum > {1'b0, r_f_stop}) ? r_f_stop : w_sum[N-1:0];
  assign w_dn_fcw = (w_diff[N] || (w_diff[N-1:0] < r_f_start)) ? r_f_start : w_diff[N-1:0];

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    w_state_next   = r_state;
    w_fcw_next     = r_fcw;
    w_nco_rst_next = 1'b0;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_err_next     = 1'b0;
    w_dir_next     = r_dir;
    w_cnt_next     = r_cnt;
    w_mode_next    = r_mode;
    w_f_start_next = r_f_start;
    w_f_stop_next  = r_f_stop;
    w_f_step_next  = r_f_step;
    w_dwell_next   = r_dwell;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if ((f_step != '0) && (f_stop >= f_start)) begin
            w_mode_next    = mode;
            w_f_start_next = f_start;
            w_f_stop_next  = f_stop;
            w_f_step_next  = f_step;
            w_dwell_next   = dwell;
            w_fcw_next     = f_start;
            w_nco_rst_next = 1'b1;
            w_busy_next    = 1'b1;
            w_cnt_next     = dwell;
            w_dir_next     = 1'b0;
            w_state_next   = S_DWELL;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end

      S_DWELL: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - D'(1);
        end else begin
          w_cnt_next = r_dwell;
          if (!r_dir) begin
            if (r_fcw == r_f_stop) begin
              case (r_mode)
                2'd1: w_fcw_next = r_f_start;
                2'd2: begin
                  // Turn around: the endpoint is held once, then step down
                  w_dir_next = 1'b1;
                  w_fcw_next = w_dn_fcw;
                end
                default: begin
                  w_state_next = S_IDLE;
                  w_busy_next  = 1'b0;
                  w_done_next  = 1'b1;
                end
              endcase
            end else begin
              w_fcw_next = w_up_fcw;
            end
          end else begin
            if (r_fcw == r_f_start) begin
              w_dir_next = 1'b0;
              w_fcw_next = w_up_fcw;
            end else begin
              w_fcw_next = w_dn_fcw;
            end
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_fcw     <= '0;
      r_nco_rst <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_mode    <= '0;
      r_f_start <= '0;
      r_f_stop  <= '0;
      r_f_step  <= '0;
      r_dwell   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_fcw     <= w_fcw_next;
      r_nco_rst <= w_nco_rst_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
      r_dir     <= w_dir_next;
      r_cnt     <= w_cnt_next;
      r_mode    <= w_mode_next;
      r_f_start <= w_f_start_next;
      r_f_stop  <= w_f_stop_next;
      r_f_step  <= w_f_step_next;
      r_dwell   <= w_dwell_next;
    end
  end

  assign fcw     = r_fcw;
  assign nco_rst = r_nco_rst;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

endmodule
